// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the LSU memory stage.
// - MIPS load/store opcodes (also consumed by the decode stage)
// - FSM state encoding and access-size encoding
// - Small decode helpers used by the memory stage
package lsu_mem_stage_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  function automatic logic op_is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic op_is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Non-memory opcodes fall into the default and report word size; callers
  // only use the size when the op is a load or store.
  function automatic lsu_size_e op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

  function automatic logic op_is_signed(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  function automatic logic size_misaligned(input lsu_size_e sz, input logic [1:0] lsb);
    case (sz)
      SZ_HALF: return lsb[0];
      SZ_WORD: return lsb != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data alignment: picks the addressed byte/half lane out of an aligned
// 32-bit read word and sign- or zero-extends it to 32 bits.
// Ports:
//   i_rdata   aligned read word from memory
//   i_lane    byte address bits [1:0] of the access
//   i_size    access size (byte/half/word)
//   i_signed  1 = sign-extend, 0 = zero-extend
//   o_result  extended load value
module lsu_load_align
  import lsu_mem_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lane,
  input  lsu_size_e   i_size,
  input  logic        i_signed,
  output logic [31:0] o_result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (i_lane)
      2'd0:    byte_sel = i_rdata[7:0];
      2'd1:    byte_sel = i_rdata[15:8];
      2'd2:    byte_sel = i_rdata[23:16];
      default: byte_sel = i_rdata[31:24];
    endcase
    // Halves are only ever accessed at lane 0 or 2 (aligned).
    half_sel = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_result = i_rdata;
    case (i_size)
      SZ_BYTE: o_result = {{24{i_signed & byte_sel[7]}}, byte_sel};
      SZ_HALF: o_result = {{16{i_signed & half_sel[15]}}, half_sel};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory stage after the ALU. Accepts one op at a time, runs at most one
// request/ack transaction on the data-memory port and returns a single
// writeback beat. Non-memory ops and misaligned accesses skip the memory port.
// Ports:
//   i_clk, i_rst_n              clock, async active-low reset
//   i_valid/o_ready             op input; accepted when both are 1 (o_ready=1 only in IDLE)
//   i_opcode,i_addr,i_wdata,i_rd op fields (addr = ALU result, wdata = rt)
//   o_valid,o_wb_en,o_rdata,o_rd,o_addr_err,o_bus_err  one-cycle writeback beat
//   o_mem_req,o_mem_we,o_mem_addr,o_mem_be,o_mem_wdata  memory request, held until ack/timeout
//   i_mem_ack,i_mem_rdata       memory completion and aligned read word
//   o_dbg_state                 current FSM state
//
// Handshakes: upstream holds op fields stable while i_valid=1 and o_ready=0;
// the op is taken on a rising edge where i_valid && o_ready. The memory
// request is o_mem_req level, held with stable o_mem_* until a cycle with
// i_mem_ack=1 (which completes it) or until the timeout expires. i_mem_ack
// is ignored whenever no request is outstanding. o_valid is a single-cycle
// beat with no back-pressure.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [5:0]  i_opcode,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd,
  output logic        o_valid,
  output logic        o_wb_en,
  output logic [31:0] o_rdata,
  output logic [4:0]  o_rd,
  output logic        o_addr_err,
  output logic        o_bus_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output lsu_state_e  o_dbg_state
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  // Last no-ack cycle: the counter reaches TIMEOUT on this cycle's edge.
  localparam cnt_t CNT_LAST = cnt_t'(TIMEOUT - 1);

  lsu_state_e  state_q;
  cnt_t        cnt_q, cnt_d;
  lsu_size_e   size_q;
  logic        signed_q, is_load_q;
  logic [1:0]  lane_q;
  logic        valid_q, wb_en_q, addr_err_q, bus_err_q;
  logic [31:0] rdata_q;
  logic [4:0]  rd_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;

  // Decode of the op being presented.
  logic        acc_load, acc_store, acc_mem, acc_signed, acc_misal;
  lsu_size_e   acc_size;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata;
  logic [31:0] load_result;

  always_comb begin
    acc_load   = op_is_load(i_opcode);
    acc_store  = op_is_store(i_opcode);
    acc_mem    = acc_load | acc_store;
    acc_size   = op_size(i_opcode);
    acc_signed = op_is_signed(i_opcode);
    acc_misal  = acc_mem & size_misaligned(acc_size, i_addr[1:0]);
    acc_be     = 4'b1111;
    acc_wdata  = i_wdata;
    case (acc_size)
      SZ_BYTE: begin
        acc_be    = 4'b0001 << i_addr[1:0];
        acc_wdata = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        acc_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        acc_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        acc_be    = 4'b1111;
        acc_wdata = i_wdata;
      end
    endcase
    cnt_d = cnt_q + 1'b1;
  end

  lsu_load_align u_load_align (
    .i_rdata  (i_mem_rdata),
    .i_lane   (lane_q),
    .i_size   (size_q),
    .i_signed (signed_q),
    .o_result (load_result)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      size_q      <= SZ_WORD;
      signed_q    <= 1'b0;
      is_load_q   <= 1'b0;
      lane_q      <= 2'b00;
      valid_q     <= 1'b0;
      wb_en_q     <= 1'b0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      rdata_q     <= '0;
      rd_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            rd_q      <= i_rd;
            cnt_q     <= '0;
            size_q    <= acc_size;
            signed_q  <= acc_signed;
            lane_q    <= i_addr[1:0];
            is_load_q <= acc_load;
            if (acc_mem && !acc_misal) begin
              state_q     <= ST_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= acc_store;
              mem_addr_q  <= {i_addr[31:2], 2'b00};
              mem_be_q    <= acc_be;
              mem_wdata_q <= acc_wdata;
            end else begin
              // Pass-through value or misaligned access: beat next cycle.
              state_q    <= ST_RESP;
              valid_q    <= 1'b1;
              wb_en_q    <= !acc_mem;
              addr_err_q <= acc_mem;
              rdata_q    <= acc_mem ? 32'h0 : i_addr;
            end
          end
        end
        ST_REQ: begin
          if (i_mem_ack) begin
            // Ack wins even on the cycle the counter would expire.
            state_q   <= ST_RESP;
            mem_req_q <= 1'b0;
            valid_q   <= 1'b1;
            wb_en_q   <= is_load_q;
            rdata_q   <= is_load_q ? load_result : 32'h0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= ST_RESP;
            cnt_q     <= cnt_d;
            mem_req_q <= 1'b0;
            valid_q   <= 1'b1;
            wb_en_q   <= 1'b0;
            bus_err_q <= 1'b1;
            rdata_q   <= 32'h0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_RESP: begin
          state_q    <= ST_IDLE;
          valid_q    <= 1'b0;
          wb_en_q    <= 1'b0;
          addr_err_q <= 1'b0;
          bus_err_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_ready     = (state_q == ST_IDLE);
  assign o_valid     = valid_q;
  assign o_wb_en     = wb_en_q;
  assign o_rdata     = rdata_q;
  assign o_rd        = rd_q;
  assign o_addr_err  = addr_err_q;
  assign o_bus_err   = bus_err_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_be    = mem_be_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_dbg_state = state_q;

endmodule
